// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator (640x480@60 Hz by default).
// Counters and every decoded output are registered on the same edge, so sync and pixel data stay aligned.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       next_frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Decode bounds are one bit wider so a boundary equal to 1024 does not wrap.
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        ASSERTED = 1'(SYNC_POL);

    logic [9:0]  x_nxt;
    logic [9:0]  y_nxt;
    logic [10:0] xw;
    logic [10:0] yw;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (pix_ce) begin
            if (x == H_LAST) begin
                x_nxt = '0;
                y_nxt = (y == V_LAST) ? '0 : y + 10'd1;
            end else begin
                x_nxt = x + 10'd1;
            end
        end
    end

    assign xw = {1'b0, x_nxt};
    assign yw = {1'b0, y_nxt};

    // Outputs decode the next counter values, so they land on the same edge as x/y.
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= H_LAST;
            y          <= V_LAST;
            active     <= 1'b0;
            hsync      <= ~ASSERTED;
            vsync      <= ~ASSERTED;
            next_frame <= 1'b0;
        end else begin
            x          <= x_nxt;
            y          <= y_nxt;
            active     <= (xw < H_ACT) && (yw < V_ACT);
            hsync      <= ((xw >= HS_BEGIN) && (xw < HS_END)) ? ASSERTED : ~ASSERTED;
            vsync      <= ((yw >= VS_BEGIN) && (yw < VS_END)) ? ASSERTED : ~ASSERTED;
            // Only a real advance onto (0, V_ACTIVE) fires; a stalled counter self-clears the pulse.
            next_frame <= pix_ce && (x_nxt == '0) && (yw == V_ACT);
        end
    end

endmodule
